// File: rtl/i2c_seq_pkg.sv
// Shared types and default constants for the I2C command sequencer.
// Imported by the condition detector and the sequencer top.
package i2c_seq_pkg;

  localparam int unsigned DEF_DEPTH          = 4;
  localparam int unsigned DEF_START_PULSE    = 5;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 50000;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LAUNCH     = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_STOP  = 3'd3,
    ST_RESP       = 3'd4
  } state_e;

  typedef struct packed {
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic       rw;
  } cmd_t;

endpackage

// File: rtl/i2c_cond_detect.sv
// Two-flop synchronizer on the observed bus lines followed by START/STOP
// detection. Each detected condition is reported as a registered 1-cycle pulse.
module i2c_cond_detect
  import i2c_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       sda_prev_q, sda_prev_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;

  // START is an sda fall while scl is high; STOP is an sda rise while scl is high.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
    sda_prev_d = sda_sync_q[1];
    start_d    = scl_sync_q[1] & sda_prev_q & ~sda_sync_q[1];
    stop_d     = scl_sync_q[1] & ~sda_prev_q & sda_sync_q[1];
  end

  // Sync flops reset to the idle-bus level so release from reset creates no event.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      sda_prev_q <= 1'b1;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      sda_prev_q <= sda_prev_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign start_o = start_q;
  assign stop_o  = stop_q;

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues host I2C commands, launches them one at a time on an i2c_master and
// reports completion (or timeout) by watching START/STOP on the bus.
module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int unsigned DEPTH          = DEF_DEPTH,
  parameter int unsigned START_PULSE    = DEF_START_PULSE,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_dev_addr,
  input  logic [7:0] cmd_reg_addr,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_rw,
  output logic [6:0] m_dev_addr,
  output logic [7:0] m_reg_addr,
  output logic [7:0] m_wdata,
  output logic       m_rw,
  output logic       m_start_tx,
  input  logic [7:0] m_rdata,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_timeout,
  output logic       busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned PLS_W = $clog2(START_PULSE) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PLS_W-1:0] PLS_LAST  = PLS_W'(START_PULSE - 1);

  state_e             state_q, state_d;
  cmd_t               fifo_mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  cmd_t               m_cmd_q, m_cmd_d;
  logic [PLS_W-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               start_seen_q, start_seen_d;
  logic               m_start_tx_q, m_start_tx_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_rdata_q, rsp_rdata_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic               busy_q, busy_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               start_s, stop_s, push_s, pop_s, tmo_hit_s;
  cmd_t               cmd_in_s;

  i2c_cond_detect u_cond_detect (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (scl_i),
    .sda_i   (sda_i),
    .start_o (start_s),
    .stop_o  (stop_s)
  );

  assign cmd_in_s = {cmd_dev_addr, cmd_reg_addr, cmd_wdata, cmd_rw};

  // FIFO bookkeeping; the push qualifier is the registered !full, so a same-cycle pop never frees a slot early.
  always_comb begin
    push_s   = cmd_valid & cmd_ready_q;
    pop_s    = (state_q == ST_IDLE) && (count_q != '0);
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Sequencer next-state and response capture.
  always_comb begin
    state_d       = state_q;
    m_cmd_d       = m_cmd_q;
    pulse_cnt_d   = pulse_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    start_seen_d  = start_seen_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = 1'b0;
    tmo_hit_s     = (tmo_cnt_q == TMO_LAST);
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          m_cmd_d      = fifo_mem_q[rd_ptr_q];
          pulse_cnt_d  = '0;
          tmo_cnt_d    = '0;
          start_seen_d = 1'b0;
          state_d      = ST_LAUNCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        start_seen_d = start_seen_q | start_s;
        if (tmo_hit_s) begin
          rsp_rdata_d   = 8'h00;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else if (pulse_cnt_q == PLS_LAST) begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          state_d   = ST_WAIT_START;
        end else begin
          tmo_cnt_d   = tmo_cnt_q + TMO_W'(1);
          pulse_cnt_d = pulse_cnt_q + PLS_W'(1);
        end
      end
      ST_WAIT_START: begin
        if (tmo_hit_s) begin
          rsp_rdata_d   = 8'h00;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else if (start_s || start_seen_q) begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          state_d   = ST_WAIT_STOP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      ST_WAIT_STOP: begin
        // A STOP in the same cycle as the timeout still completes normally.
        if (stop_s) begin
          rsp_rdata_d = m_cmd_q.rw ? m_rdata : 8'h00;
          state_d     = ST_RESP;
        end else if (tmo_hit_s) begin
          rsp_rdata_d   = 8'h00;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state values so they align with the state they describe.
  always_comb begin
    m_start_tx_d = (state_d == ST_LAUNCH);
    rsp_valid_d  = (state_d == ST_RESP);
    busy_d       = (count_d != '0) || (state_d != ST_IDLE);
    cmd_ready_d  = (count_d != DEPTH_C);
  end

  // Command storage; stale entries are harmless because the pointers reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= cmd_in_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      m_cmd_q       <= '0;
      pulse_cnt_q   <= '0;
      tmo_cnt_q     <= '0;
      start_seen_q  <= 1'b0;
      m_start_tx_q  <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 8'h00;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      cmd_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      m_cmd_q       <= m_cmd_d;
      pulse_cnt_q   <= pulse_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      start_seen_q  <= start_seen_d;
      m_start_tx_q  <= m_start_tx_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign m_dev_addr  = m_cmd_q.dev_addr;
  assign m_reg_addr  = m_cmd_q.reg_addr;
  assign m_wdata     = m_cmd_q.wdata;
  assign m_rw        = m_cmd_q.rw;
  assign m_start_tx  = m_start_tx_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench for i2c_cmd_sequencer: a vector table, randomized commands
// against a response model, and hand-written full/reset/idle-event sequences.
module tb_i2c_cmd_sequencer;
  import i2c_seq_pkg::*;

  localparam int SP  = 5;
  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [6:0] cmd_dev_addr;
  logic [7:0] cmd_reg_addr, cmd_wdata;
  logic       cmd_rw;
  logic [6:0] m_dev_addr;
  logic [7:0] m_reg_addr, m_wdata;
  logic       m_rw, m_start_tx;
  logic [7:0] m_rdata;
  logic       scl_i, sda_i;
  logic       rsp_valid, rsp_timeout, busy;
  logic [7:0] rsp_rdata;

  i2c_cmd_sequencer #(.DEPTH(4), .START_PULSE(SP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .cmd_rw(cmd_rw), .m_dev_addr(m_dev_addr), .m_reg_addr(m_reg_addr), .m_wdata(m_wdata),
    .m_rw(m_rw), .m_start_tx(m_start_tx), .m_rdata(m_rdata), .scl_i(scl_i), .sda_i(sda_i),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    cmd_t       c;
    logic [7:0] sdata;
    bit         tmo;
    bit         early;
    logic [7:0] exp_rdata;
    bit         exp_tmo;
  } vec_t;

  vec_t tbl [7];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [6:0] d, input logic [7:0] r, input logic [7:0] w,
                              input logic rw, input logic [7:0] sd, input bit tmo,
                              input bit early, input logic [7:0] er, input bit et);
    vec_t v;
    v.c = {d, r, w, rw};
    v.sdata = sd; v.tmo = tmo; v.early = early; v.exp_rdata = er; v.exp_tmo = et;
    return v;
  endfunction

  // Reference response: timeouts report 0x00, reads report the slave byte, writes report 0x00.
  function automatic logic [8:0] ref_rsp(input logic rw, input logic [7:0] sd, input bit tmo);
    if (tmo) return {1'b1, 8'h00};
    return {1'b0, rw ? sd : 8'h00};
  endfunction

  task automatic push(input cmd_t c, input int budget, output bit ok);
    {cmd_dev_addr, cmd_reg_addr, cmd_wdata, cmd_rw} = c;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      ok = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  // Waits for the launch pulse, checks operands and pulse width; optionally drives START mid-pulse.
  task automatic wait_launch(input cmd_t c, input bit early, output int lat);
    int width;
    lat = 0;
    while (!m_start_tx && lat < 200) begin tick(); lat++; end
    chk("launch_seen", 32'(m_start_tx), 32'd1);
    chk("operands", 32'({m_dev_addr, m_reg_addr, m_wdata, m_rw}), 32'(c));
    width = 0;
    while (m_start_tx && width < 20) begin
      if (early && width == 1) sda_i = 1'b0;
      tick();
      width++;
    end
    chk("start_width", 32'(width), 32'(SP));
  endtask

  // Plays the bus (START, SCL activity, STOP) unless a timeout is wanted, then checks the response.
  task automatic finish(input logic [7:0] sdata, input bit tmo, input bit early,
                        input logic [7:0] exp_rdata, input bit exp_tmo, input int g1, input int g2);
    int n;
    if (!tmo) begin
      m_rdata = sdata;
      if (!early) begin repeat (g1) tick(); sda_i = 1'b0; end
      repeat (3) tick();
      scl_i = 1'b0;
      repeat (g2) tick();
      scl_i = 1'b1;
      tick(); tick();
      sda_i = 1'b1;
    end else begin
      m_rdata = 8'($urandom);
    end
    n = 0;
    while (!rsp_valid && n < 300) begin tick(); n++; end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_tmo));
    if (tmo) chk("timeout_cycle", 32'(n), 32'(TMO - SP));
    tick();
    chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    chk("rsp_rdata_hold", 32'(rsp_rdata), 32'(exp_rdata));
    scl_i = 1'b1;
    sda_i = 1'b1;
  endtask

  cmd_t       rc, a_cmd;
  cmd_t       b_cmd [5];
  logic [7:0] b_sd [4];
  logic [7:0] rsd;
  logic [8:0] rexp;
  bit         ok, rtmo, rearly;
  int         lat, ev;

  initial begin
    tbl[0] = mk(7'h11, 8'h00, 8'hAA, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0);
    tbl[1] = mk(7'h11, 8'h00, 8'h00, 1'b1, 8'hAA, 1'b0, 1'b0, 8'hAA, 1'b0);
    tbl[2] = mk(7'h7F, 8'hFF, 8'hFF, 1'b0, 8'h33, 1'b0, 1'b1, 8'h00, 1'b0);
    tbl[3] = mk(7'h00, 8'h80, 8'h01, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    tbl[4] = mk(7'h11, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    tbl[5] = mk(7'h2A, 8'h55, 8'hC3, 1'b1, 8'h5C, 1'b0, 1'b1, 8'h5C, 1'b0);
    tbl[6] = mk(7'h3C, 8'h01, 8'h99, 1'b1, 8'hEE, 1'b1, 1'b0, 8'h00, 1'b1);

    rst = 1'b1; cmd_valid = 1'b0; cmd_dev_addr = '0; cmd_reg_addr = '0; cmd_wdata = '0;
    cmd_rw = 1'b0; m_rdata = 8'h00; scl_i = 1'b1; sda_i = 1'b1;
    repeat (3) tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_outputs", 32'({m_dev_addr, m_reg_addr, m_wdata, m_rw}), 32'd0);
    chk("rst_flags", 32'({m_start_tx, rsp_valid, rsp_timeout, busy}), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      chk("idle_before", 32'(busy), 32'd0);
      push(tbl[i].c, 20, ok);
      chk("accepted", 32'(ok), 32'd1);
      wait_launch(tbl[i].c, tbl[i].early, lat);
      chk("latency", 32'(lat), 32'd1);
      finish(tbl[i].sdata, tbl[i].tmo, tbl[i].early, tbl[i].exp_rdata, tbl[i].exp_tmo, 2, 4);
    end

    for (int r = 0; r < 16; r++) begin
      rc = 24'($urandom);
      rsd = 8'($urandom);
      rtmo = ($urandom_range(0, 5) == 0);
      rearly = !rtmo && ($urandom_range(0, 1) == 1);
      rexp = ref_rsp(rc.rw, rsd, rtmo);
      push(rc, 20, ok);
      chk("rnd_accepted", 32'(ok), 32'd1);
      wait_launch(rc, rearly, lat);
      chk("rnd_latency", 32'(lat), 32'd1);
      finish(rsd, rtmo, rearly, rexp[7:0], rexp[8], $urandom_range(0, 5), $urandom_range(1, 8));
    end

    // Full FIFO while a transaction is in flight, then in-order drain with one IDLE cycle between.
    a_cmd = {7'h50, 8'h10, 8'h20, 1'b1};
    push(a_cmd, 20, ok);
    for (int k = 0; k < 5; k++) begin
      b_cmd[k] = {7'(7'h60 + k), 8'(8'h20 + k), 8'(8'h40 + k), 1'b1};
    end
    for (int k = 0; k < 4; k++) begin
      b_sd[k] = 8'(8'hB0 + k);
      push(b_cmd[k], 20, ok);
      chk("b2b_accept", 32'(ok), 32'd1);
    end
    chk("full_ready_low", 32'(cmd_ready), 32'd0);
    push(b_cmd[4], 10, ok);
    chk("full_reject", 32'(ok), 32'd0);
    chk("a_operands_held", 32'({m_dev_addr, m_reg_addr, m_wdata, m_rw}), 32'(a_cmd));
    finish(8'h77, 1'b0, 1'b0, 8'h77, 1'b0, 1, 2);
    for (int k = 0; k < 4; k++) begin
      wait_launch(b_cmd[k], 1'b0, lat);
      chk("b2b_gap", 32'(lat), 32'd1);
      finish(b_sd[k], 1'b0, 1'b0, b_sd[k], 1'b0, 1, 2);
    end
    chk("b2b_busy_done", 32'(busy), 32'd0);

    // Reset while m_start_tx is high.
    push(tbl[0].c, 20, ok);
    tick();
    chk("launch_pre_rst", 32'(m_start_tx), 32'd1);
    rst = 1'b1;
    tick();
    chk("launch_rst_drop", 32'(m_start_tx), 32'd0);
    rst = 1'b0;
    tick();

    // Reset in WAIT_STOP with two commands queued.
    push(tbl[1].c, 20, ok);
    wait_launch(tbl[1].c, 1'b0, lat);
    sda_i = 1'b0;
    repeat (6) tick();
    push(tbl[2].c, 20, ok);
    push(tbl[3].c, 20, ok);
    chk("queued_busy", 32'(busy), 32'd1);
    rst = 1'b1; scl_i = 1'b1; sda_i = 1'b1;
    tick();
    chk("rst_mid_start_tx", 32'(m_start_tx), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    ev = 0;
    for (int t = 0; t < 40; t++) begin
      if (t == 5) sda_i = 1'b0;
      if (t == 12) sda_i = 1'b1;
      tick();
      ev += int'(rsp_valid) + int'(m_start_tx) + int'(busy);
    end
    chk("post_rst_quiet", 32'(ev), 32'd0);

    push(tbl[5].c, 20, ok);
    chk("after_idle_ev_accept", 32'(ok), 32'd1);
    wait_launch(tbl[5].c, 1'b0, lat);
    chk("after_idle_ev_latency", 32'(lat), 32'd1);
    finish(8'h3D, 1'b0, 1'b0, 8'h3D, 1'b0, 2, 3);
    chk("final_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_sequencer.md
I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two).
REQ-002 SHALL have parameter START_PULSE, default 5, meaning clk cycles m_start_tx is held high.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning the maximum number of cycles from launch to STOP.
REQ-004 SHALL have one clock and a synchronous active-high reset.
REQ-005 SHALL have port clk, input, 1 bit: system clock (50 MHz).
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1): host command handshake.
REQ-008 SHALL have ports cmd_dev_addr (input, 7), cmd_reg_addr (input, 8), cmd_wdata (input, 8) and cmd_rw (input, 1; 1=read): command fields.
REQ-009 SHALL have ports m_dev_addr (output, 7), m_reg_addr (output, 8), m_wdata (output, 8) and m_rw (output, 1): operands to i2c_master.
REQ-010 SHALL have port m_start_tx, output, 1 bit: launch pulse to i2c_master.
REQ-011 SHALL have port m_rdata, input, 8 bits: read byte from i2c_master data_o.
REQ-012 SHALL have ports scl_i (input, 1) and sda_i (input, 1): observed I2C bus lines.
REQ-013 SHALL have ports rsp_valid (output, 1), rsp_rdata (output, 8) and rsp_timeout (output, 1): completion report.
REQ-014 SHALL have port busy, output, 1 bit: FIFO non-empty or FSM not IDLE.

Function
REQ-015 SHALL accept a command on a rising clk edge when cmd_valid and cmd_ready are both high; cmd_ready = !full.
REQ-016 SHALL drop no command and overwrite no FIFO entry; when full, cmd_ready is low and a push is not taken, even if a pop occurs in the same cycle.
REQ-017 SHALL pass scl_i and sda_i through a 2-flop synchronizer, then detect START (sda fall while scl high) and STOP (sda rise while scl high), each as a 1-cycle pulse.
REQ-018 SHALL implement FSM states IDLE, LAUNCH, WAIT_START, WAIT_STOP and RESP.
REQ-019 IDLE: if the FIFO is non-empty, pop the head, register its fields onto the m_* operand outputs and go to LAUNCH on the next edge; otherwise stay.
REQ-020 LAUNCH: m_start_tx is high for exactly START_PULSE cycles, then go to WAIT_START.
REQ-021 WAIT_START: on START go to WAIT_STOP; a START seen during LAUNCH also counts.
REQ-022 WAIT_STOP: on STOP capture m_rdata (reads) or 0x00 (writes) into rsp_rdata and go to RESP.
REQ-023 RESP: rsp_valid is high for one cycle with rsp_timeout=0, then go to IDLE.
REQ-024 SHALL run a timeout counter that clears on entering LAUNCH and counts in LAUNCH, WAIT_START and WAIT_STOP.
REQ-025 At TIMEOUT_CYCLES-1 the timeout SHALL force RESP with rsp_timeout=1 and rsp_rdata=0x00; if STOP and timeout coincide, STOP wins.
REQ-026 SHALL hold the m_* operands stable from LAUNCH until the return to IDLE.
REQ-027 Latency: a command accepted into an empty FIFO while in IDLE SHALL raise m_start_tx on the 2nd rising edge after acceptance.
REQ-028 Back-to-back commands SHALL incur exactly one IDLE cycle between RESP and the next LAUNCH.
REQ-029 SHALL provide no backpressure on rsp; rsp_rdata holds its value until the next RESP.
REQ-030 SHALL ignore START/STOP events seen in IDLE and RESP.

Reset
REQ-031 On rst, the FIFO SHALL be emptied, FSM=IDLE, counters=0 and synchronizer flops=1.
REQ-032 On rst, all outputs SHALL be 0 except cmd_ready=1.
REQ-033 Reset mid-transaction SHALL drop m_start_tx on the next edge, emit no rsp_valid and discard queued commands.

Structure
REQ-034 Package i2c_seq_pkg SHALL hold the FSM state enum, the command struct {dev_addr[6:0], reg_addr[7:0], wdata[7:0], rw} and the default parameter constants.
REQ-035 Sub-module i2c_cond_detect SHALL contain the synchronizer and the START/STOP detector; the FIFO and FSM stay inline.

Verification
REQ-036 Write 0x11/0x00/0xAA, rw=0, with i2c_master+i2c_slave(0x11) -> m_start_tx high 5 cycles starting 2 edges after accept; one rsp_valid, rsp_timeout=0, rsp_rdata=0x00.
REQ-037 Read 0x11/0x00, rw=1, slave returns 0xAA -> rsp_valid with rsp_rdata=0xAA and rsp_timeout=0.
REQ-038 Push 5 commands back-to-back with DEPTH=4 and a busy master -> cmd_ready low after 4 accepted; all 4 responses arrive in order; busy is low after the last.
REQ-039 TIMEOUT_CYCLES=100, bus held high (no master) -> rsp_valid at cycle 100 after LAUNCH entry with rsp_timeout=1 and rsp_rdata=0x00.
REQ-040 rst asserted during WAIT_STOP with 2 commands queued -> next cycle m_start_tx=0, busy=0, cmd_ready=1; no rsp_valid ever.
REQ-041 START/STOP injected while in IDLE -> no state change; the next command completes normally.
